// File: rtl/booth_pkg.sv
// Shared constants, state and Booth-operation encodings for the radix-2 Booth multiplier.
package booth_pkg;

  localparam int W    = 8;
  localparam int ITER = 8;
  localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rca8.sv
// 8-bit ripple-carry adder with carry-out and signed-overflow flag.
module rca8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c_in,
  output logic [7:0] z,
  output logic       c_out,
  output logic       ovr
);

  logic [8:0] c;

  always_comb begin
    c[0] = c_in;
    for (int i = 0; i < 8; i++) begin
      z[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign c_out = c[8];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovr   = c[7] ^ c[8];

endmodule

// File: rtl/booth_mul8.sv
// Sequential signed 8x8 radix-2 Booth multiplier: one add/sub + arithmetic shift per clock,
// eight iterations per product, start/done handshake.
module booth_mul8
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           rst_b,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   m_q, m_d;
  logic           q1_q, q1_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [2*W-1:0] z_q, z_d;

  booth_op_t      op;
  logic [W-1:0]   add_y;
  logic           add_cin;
  logic [W-1:0]   sum;
  logic           ovr;
  logic           c_out_unused;
  logic           load;

  rca8 u_rca8 (
    .x     (a_q),
    .y     (add_y),
    .c_in  (add_cin),
    .z     (sum),
    .c_out (c_out_unused),
    .ovr   (ovr)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  // DONE also accepts a new request so back-to-back products issue every 9 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op      = booth_decode(q_q[0], q1_q);
    add_y   = '0;
    add_cin = 1'b0;
    case (op)
      OP_ADD: add_y = m_q;
      OP_SUB: begin
        add_y   = ~m_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase

    load  = (state_q != RUN) && (state_q != 2'b11) && start;
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    z_d   = z_q;
    if (load) begin
      a_d   = '0;
      q_d   = y;
      q1_d  = 1'b0;
      m_d   = x;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      // Shift in the true 9-bit sign so that M = -128 still yields the right result.
      a_d   = {sum[W-1] ^ ovr, sum[W-1:1]};
      q_d   = {sum[0], q_q[W-1:1]};
      q1_d  = q_q[0];
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST_CNT) z_d = {a_d, q_d};
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    z    = z_q;
  end

endmodule
